// File: rtl/nf10_rr_input_arbiter.sv
// Five-input AXI4-Stream packet round-robin arbiter with per-input fall-through FIFOs.
// Optional build macro NF10_ARB_SRC_STAMP_EN stamps a one-hot source port into TUSER on first beats.
module nf10_rr_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int FIFO_DEPTH_BITS      = 2
) (
    input  logic                                 AXI_ACLK,
    input  logic                                 AXI_RESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S0_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S0_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S0_AXIS_TUSER,
    input  logic                                 S0_AXIS_TVALID,
    output logic                                 S0_AXIS_TREADY,
    input  logic                                 S0_AXIS_TLAST,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S1_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S1_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S1_AXIS_TUSER,
    input  logic                                 S1_AXIS_TVALID,
    output logic                                 S1_AXIS_TREADY,
    input  logic                                 S1_AXIS_TLAST,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S2_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S2_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S2_AXIS_TUSER,
    input  logic                                 S2_AXIS_TVALID,
    output logic                                 S2_AXIS_TREADY,
    input  logic                                 S2_AXIS_TLAST,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S3_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S3_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S3_AXIS_TUSER,
    input  logic                                 S3_AXIS_TVALID,
    output logic                                 S3_AXIS_TREADY,
    input  logic                                 S3_AXIS_TLAST,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S4_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S4_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      S4_AXIS_TUSER,
    input  logic                                 S4_AXIS_TVALID,
    output logic                                 S4_AXIS_TREADY,
    input  logic                                 S4_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
    output logic                                 M_AXIS_TVALID,
    input  logic                                 M_AXIS_TREADY,
    output logic                                 M_AXIS_TLAST
);
    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int SW     = DW / 8;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int BW     = 1 + UW + SW + DW;
    localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int CW     = FIFO_DEPTH_BITS + 1;
    localparam int NUM_IN = 5;

    if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH || C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH
        || SRC_PORT_POS + 8 > C_M_AXIS_TUSER_WIDTH) begin : g_param_check
        $error("nf10_rr_input_arbiter: inconsistent width parameters");
    end

    typedef enum logic {SELECT = 1'b0, SEND = 1'b1} state_t;

    state_t                     state, state_nxt;
    logic [2:0]                 cur, cur_nxt, rr_ptr, rr_ptr_nxt, cand;
    logic                       found;
    logic [BW-1:0]              in_beat [NUM_IN];
    logic [BW-1:0]              mem [NUM_IN][DEPTH];
    logic [BW-1:0]              head;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr [NUM_IN];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr [NUM_IN];
    logic [CW-1:0]              count [NUM_IN];
    logic [NUM_IN-1:0]          in_valid, in_ready, wr_en, rd_en, empty;

    assign in_beat[0] = {S0_AXIS_TLAST, S0_AXIS_TUSER, S0_AXIS_TSTRB, S0_AXIS_TDATA};
    assign in_beat[1] = {S1_AXIS_TLAST, S1_AXIS_TUSER, S1_AXIS_TSTRB, S1_AXIS_TDATA};
    assign in_beat[2] = {S2_AXIS_TLAST, S2_AXIS_TUSER, S2_AXIS_TSTRB, S2_AXIS_TDATA};
    assign in_beat[3] = {S3_AXIS_TLAST, S3_AXIS_TUSER, S3_AXIS_TSTRB, S3_AXIS_TDATA};
    assign in_beat[4] = {S4_AXIS_TLAST, S4_AXIS_TUSER, S4_AXIS_TSTRB, S4_AXIS_TDATA};
    assign in_valid   = {S4_AXIS_TVALID, S3_AXIS_TVALID, S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};
    assign {S4_AXIS_TREADY, S3_AXIS_TREADY, S2_AXIS_TREADY, S1_AXIS_TREADY, S0_AXIS_TREADY} = in_ready;

    // Ready drops one entry early, so usable capacity is DEPTH-1 beats.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            empty[i]    = (count[i] == '0);
            in_ready[i] = AXI_RESETN & (count[i] < CW'(DEPTH - 1));
            wr_en[i]    = in_valid[i] & in_ready[i];
        end
    end

    always_comb begin
        rd_en = '0;
        if (state == SEND && M_AXIS_TVALID && M_AXIS_TREADY) rd_en[cur] = 1'b1;
    end

    always_ff @(posedge AXI_ACLK) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en[i]) mem[i][wr_ptr[i]] <= in_beat[i];
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < NUM_IN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CW'(wr_en[i]) - CW'(rd_en[i]);
            end
        end
    end

`ifdef NF10_ARB_SRC_STAMP_EN
    logic first_beat;

    function automatic logic [7:0] src_onehot(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h01;
            3'd1:    return 8'h04;
            3'd2:    return 8'h10;
            3'd3:    return 8'h40;
            default: return 8'h02;
        endcase
    endfunction

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN)                         first_beat <= 1'b1;
        else if (state == SELECT)                first_beat <= 1'b1;
        else if (M_AXIS_TVALID && M_AXIS_TREADY) first_beat <= 1'b0;
    end
`endif

    always_comb begin
        head          = mem[cur][rd_ptr[cur]];
        M_AXIS_TVALID = AXI_RESETN & (state == SEND) & ~empty[cur];
        M_AXIS_TDATA  = head[DW-1:0];
        M_AXIS_TSTRB  = head[DW+SW-1:DW];
        M_AXIS_TUSER  = head[DW+SW+UW-1:DW+SW];
        M_AXIS_TLAST  = head[BW-1];
`ifdef NF10_ARB_SRC_STAMP_EN
        if (first_beat) M_AXIS_TUSER[SRC_PORT_POS +: 8] = src_onehot(cur);
`endif
    end

    // Search starts at rr_ptr, which points just past the last input served.
    always_comb begin
        state_nxt  = state;
        cur_nxt    = cur;
        rr_ptr_nxt = rr_ptr;
        found      = 1'b0;
        cand       = '0;
        if (state == SELECT) begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand = 3'((int'(rr_ptr) + k) % NUM_IN);
                if (!found && !empty[cand]) begin
                    found     = 1'b1;
                    cur_nxt   = cand;
                    state_nxt = SEND;
                end
            end
        end else if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            rr_ptr_nxt = (cur == 3'd4) ? 3'd0 : cur + 3'd1;
            state_nxt  = SELECT;
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            state  <= SELECT;
            cur    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            cur    <= cur_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end
endmodule

// File: tb/tb_nf10_rr_input_arbiter.sv
// Bench for nf10_rr_input_arbiter: directed steps plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_nf10_rr_input_arbiter;
    localparam int DW = 256, SW = 32, UW = 128, SRC = 16, NI = 5, CAP = 3;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0, rstn = 1'b0;
    logic [DW-1:0] s_tdata [NI];
    logic [SW-1:0] s_tstrb [NI];
    logic [UW-1:0] s_tuser [NI];
    logic [NI-1:0] s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata;
    logic [SW-1:0] m_tstrb;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tready, m_tlast;

    always #5 clk = ~clk;

    nf10_rr_input_arbiter dut (
        .AXI_ACLK(clk), .AXI_RESETN(rstn),
        .S0_AXIS_TDATA(s_tdata[0]), .S0_AXIS_TSTRB(s_tstrb[0]), .S0_AXIS_TUSER(s_tuser[0]),
        .S0_AXIS_TVALID(s_tvalid[0]), .S0_AXIS_TREADY(s_tready[0]), .S0_AXIS_TLAST(s_tlast[0]),
        .S1_AXIS_TDATA(s_tdata[1]), .S1_AXIS_TSTRB(s_tstrb[1]), .S1_AXIS_TUSER(s_tuser[1]),
        .S1_AXIS_TVALID(s_tvalid[1]), .S1_AXIS_TREADY(s_tready[1]), .S1_AXIS_TLAST(s_tlast[1]),
        .S2_AXIS_TDATA(s_tdata[2]), .S2_AXIS_TSTRB(s_tstrb[2]), .S2_AXIS_TUSER(s_tuser[2]),
        .S2_AXIS_TVALID(s_tvalid[2]), .S2_AXIS_TREADY(s_tready[2]), .S2_AXIS_TLAST(s_tlast[2]),
        .S3_AXIS_TDATA(s_tdata[3]), .S3_AXIS_TSTRB(s_tstrb[3]), .S3_AXIS_TUSER(s_tuser[3]),
        .S3_AXIS_TVALID(s_tvalid[3]), .S3_AXIS_TREADY(s_tready[3]), .S3_AXIS_TLAST(s_tlast[3]),
        .S4_AXIS_TDATA(s_tdata[4]), .S4_AXIS_TSTRB(s_tstrb[4]), .S4_AXIS_TUSER(s_tuser[4]),
        .S4_AXIS_TVALID(s_tvalid[4]), .S4_AXIS_TREADY(s_tready[4]), .S4_AXIS_TLAST(s_tlast[4]),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
        .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast)
    );

    // Model: mq holds beats accepted into each input buffer; sq holds beats still to be offered.
    beat_t mq [NI][$];
    beat_t sq [NI][$];
    bit    m_busy = 1'b0, m_first = 1'b1;
    int    m_cur = 0, m_ptr = 0;
    logic [7:0] stamp_tbl [NI];

    int cmp_n = 0, fail_n = 0;
    int cyc = 0, vprob = 100, rprob = 100;
    bit rdy_rand = 1'b0, lat_arm = 1'b0;
    int lat_hs = -1, lat_v = -1;
    int hs_cnt [NI];
    int in_beats = 0, out_beats = 0;
    int out_tags [$];
    int last_cyc [$];
    logic [7:0] out_user8 [$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        cmp_n++;
        assert (obs === exp) else begin
            fail_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [NI-1:0] exp_rdy, s_hs;
        logic exp_v, m_hs, r;
        beat_t eb, ob;
        for (int i = 0; i < NI; i++)
            if (!s_tvalid[i] && sq[i].size() > 0 && int'($urandom_range(99)) < vprob) begin
                s_tvalid[i] = 1'b1;
                {s_tlast[i], s_tuser[i], s_tstrb[i], s_tdata[i]} = sq[i][0];
            end
        if (rdy_rand) m_tready = (int'($urandom_range(99)) < rprob);
        @(negedge clk);
        r = rstn;
        for (int i = 0; i < NI; i++) begin
            exp_rdy[i] = r && (mq[i].size() < CAP);
            check($sformatf("s%0d_tready", i), s_tready[i], exp_rdy[i]);
        end
        exp_v = r && m_busy && (mq[m_cur].size() > 0);
        check("m_tvalid", m_tvalid, exp_v);
        if (exp_v) begin
            eb = mq[m_cur][0];
`ifdef NF10_ARB_SRC_STAMP_EN
            if (m_first) eb.user[SRC +: 8] = stamp_tbl[m_cur];
`endif
            ob = {m_tlast, m_tuser, m_tstrb, m_tdata};
            check("m_beat", ob, eb);
        end
        s_hs = s_tvalid & s_tready;
        m_hs = m_tvalid & m_tready;
        if (lat_arm && s_hs[2] && lat_hs < 0) lat_hs = cyc;
        if (lat_arm && m_tvalid && lat_v < 0) lat_v = cyc;
        if (m_hs) begin
            out_beats++;
            out_user8.push_back(m_tuser[SRC +: 8]);
            if (m_tlast) begin
                out_tags.push_back(int'(m_tdata[7:0]));
                last_cyc.push_back(cyc);
            end
        end
        for (int i = 0; i < NI; i++) if (s_hs[i]) begin hs_cnt[i]++; in_beats++; end
        @(posedge clk);
        #1;
        cyc++;
        if (!r) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
            m_busy = 1'b0; m_cur = 0; m_ptr = 0; m_first = 1'b1;
        end else begin
            if (!m_busy) begin
                m_first = 1'b1;
                for (int k = 0; k < NI; k++)
                    if (!m_busy && mq[(m_ptr + k) % NI].size() > 0) begin
                        m_busy = 1'b1;
                        m_cur  = (m_ptr + k) % NI;
                    end
            end else if (exp_v && m_tready) begin
                eb = mq[m_cur].pop_front();
                m_first = 1'b0;
                if (eb.last) begin m_busy = 1'b0; m_ptr = (m_cur + 1) % NI; end
            end
            for (int i = 0; i < NI; i++)
                if (s_tvalid[i] && exp_rdy[i] && sq[i].size() > 0) mq[i].push_back(sq[i][0]);
        end
        for (int i = 0; i < NI; i++)
            if (s_hs[i]) begin
                if (sq[i].size() > 0) void'(sq[i].pop_front());
                s_tvalid[i] = 1'b0;
            end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        for (int i = 0; i < NI; i++) begin sq[i].delete(); s_tvalid[i] = 1'b0; end
        repeat (n) cycle();
        rstn = 1'b1;
        for (int i = 0; i < NI; i++) hs_cnt[i] = 0;
        out_tags.delete(); last_cyc.delete(); out_user8.delete();
        in_beats = 0; out_beats = 0;
    endtask

    task automatic add_pkt(input int i, input int len, input bit clr_src);
        beat_t b;
        for (int n = 0; n < len; n++) begin
            for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
            b.data[7:0] = 8'(i);
            for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
            if (clr_src) b.user[SRC +: 8] = 8'h00;
            b.strb = $urandom;
            b.last = (n == len - 1);
            sq[i].push_back(b);
        end
    endtask

    function automatic bit pending();
        bit p = m_busy;
        for (int i = 0; i < NI; i++) p = p || (sq[i].size() > 0) || (mq[i].size() > 0);
        return p;
    endfunction

    task automatic drain(input int limit);
        int k = 0;
        bit pend = pending();
        while (pend && k < limit) begin cycle(); k++; pend = pending(); end
        check("drain_done", pend, 1'b0);
    endtask

    task automatic check_tags(input string tag, input int exp []);
        check({tag, "_count"}, out_tags.size(), exp.size());
        for (int j = 0; j < exp.size(); j++)
            check(tag, (j < out_tags.size()) ? out_tags[j] : -1, exp[j]);
    endtask

    initial begin
        int exp2 [] = '{0, 1, 2, 3, 4, 0, 4};
        bit pat [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic [7:0] first_exp;
        stamp_tbl = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h02};
        for (int i = 0; i < NI; i++) begin
            s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; s_tdata[i] = '0; s_tstrb[i] = '0; s_tuser[i] = '0;
            hs_cnt[i] = 0;
        end
        m_tready = 1'b0;
`ifdef NF10_ARB_SRC_STAMP_EN
        first_exp = 8'h02;
`else
        first_exp = 8'h00;
`endif

        // Reset state: no valid, no ready.
        do_reset(3);

        // Single 3-beat packet on S2: two-cycle latency, beats in order.
        m_tready = 1'b1;
        lat_arm = 1'b1;
        add_pkt(2, 3, 1'b0);
        drain(50);
        lat_arm = 1'b0;
        check("t1_latency", lat_v - lat_hs, 2);
        check("t1_beats", out_beats, 3);

        // One single-beat packet on every input at once, then a new search from S0.
        do_reset(2);
        for (int i = 0; i < NI; i++) add_pkt(i, 1, 1'b0);
        drain(60);
        for (int j = 0; j < 4; j++)
            check("t2_gap", (j + 1 < last_cyc.size()) ? last_cyc[j+1] - last_cyc[j] : -1, 2);
        add_pkt(4, 1, 1'b0);
        add_pkt(0, 1, 1'b0);
        drain(30);
        check_tags("t2_order", exp2);

        // rr_ptr = 2 after an S1 packet; S3 wins over continuous S1 traffic.
        do_reset(2);
        add_pkt(1, 2, 1'b0);
        drain(30);
        out_tags.delete();
        for (int n = 0; n < 3; n++) add_pkt(1, 3, 1'b0);
        add_pkt(3, 2, 1'b0);
        drain(80);
        check_tags("t3_order", '{3, 1, 1, 1});

        // Backpressure pattern during a 4-beat S0 packet with S4 pending.
        do_reset(2);
        add_pkt(0, 4, 1'b0);
        add_pkt(4, 1, 1'b0);
        for (int k = 0; k < 12; k++) begin m_tready = pat[k]; cycle(); end
        drain(40);
        check_tags("t4_order", '{0, 4});
        check("t4_beats", out_beats, 5);

        // Input buffer fills: three beats accepted, then ready drops.
        do_reset(2);
        m_tready = 1'b0;
        add_pkt(0, 6, 1'b0);
        run(8);
        check("t5_accepted", hs_cnt[0], 3);
        check("t5_s0_ready", s_tready[0], 1'b0);
        m_tready = 1'b1;
        drain(60);
        check("t5_total", hs_cnt[0], 6);

        // Source stamp on S4, then reset in the middle of the packet.
        do_reset(2);
        add_pkt(4, 3, 1'b1);
        run(4);
        check("t6_beats_before_reset", out_user8.size(), 2);
        if (out_user8.size() >= 2) begin
            check("t6_first_src", out_user8[0], first_exp);
            check("t6_second_src", out_user8[1], 8'h00);
        end
        do_reset(2);
        add_pkt(3, 1, 1'b0);
        add_pkt(1, 1, 1'b0);
        drain(40);
        check_tags("t6_after_reset", '{1, 3});

        // Random traffic on all inputs with random backpressure.
        do_reset(2);
        rdy_rand = 1'b1; rprob = 70; vprob = 60;
        repeat (40) begin
            repeat (2) add_pkt(int'($urandom_range(4)), int'($urandom_range(1, 4)), 1'b0);
            run(20);
        end
        rprob = 100;
        drain(3000);
        check("rand_beats", out_beats, in_beats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule

// File: doc/nf10_rr_input_arbiter.md
# nf10_rr_input_arbiter

Packet-granular round-robin arbiter merging five AXI4-Stream receive interfaces (nf0–nf3 MACs plus the DMA/CPU stream) into a single stream. It feeds the router output port lookup stage directly. Each input is buffered in its own small fall-through FIFO. Packets are never interleaved: once an input is granted, it owns the output until its TLAST beat is accepted.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master TDATA width; TSTRB width is this value / 8
- C_S_AXIS_DATA_WIDTH, 256, slave TDATA width; must equal the master width
- C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
- C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width; must equal the master width
- SRC_PORT_POS, 16, LSB of the 8-bit one-hot source-port field in TUSER
- FIFO_DEPTH_BITS, 2, log2 of per-input FIFO depth; nearly_full asserts at depth−1 entries

Ports:
- AXI_ACLK  in  1  sole clock
- AXI_RESETN  in  1  synchronous, active-low reset
- Sn_AXIS_TDATA  in  C_S_AXIS_DATA_WIDTH  input n data (n = 0..4)
- Sn_AXIS_TSTRB  in  C_S_AXIS_DATA_WIDTH/8  input n byte strobes
- Sn_AXIS_TUSER  in  C_S_AXIS_TUSER_WIDTH  input n sideband
- Sn_AXIS_TVALID  in  1  input n valid
- Sn_AXIS_TREADY  out  1  input n ready
- Sn_AXIS_TLAST  in  1  input n end of packet
- M_AXIS_TDATA  out  C_M_AXIS_DATA_WIDTH  merged data
- M_AXIS_TSTRB  out  C_M_AXIS_DATA_WIDTH/8  merged strobes
- M_AXIS_TUSER  out  C_M_AXIS_TUSER_WIDTH  merged sideband
- M_AXIS_TVALID  out  1  merged valid
- M_AXIS_TREADY  in  1  downstream ready
- M_AXIS_TLAST  out  1  merged end of packet

## Operation
- Per-input FIFO:
  - Stores {TLAST, TUSER, TSTRB, TDATA}.
  - A beat is written when Sn_AXIS_TVALID & Sn_AXIS_TREADY.
  - Sn_AXIS_TREADY = AXI_RESETN & ~nearly_full[n].
  - Read and write in the same cycle are legal, and occupancy is unchanged.
- Registers:
  - state ∈ {SELECT, SEND}
  - cur[2:0] (granted input)
  - rr_ptr[2:0] (search start); both counters wrap 4→0.
- SELECT:
  - M_AXIS_TVALID = 0.
  - If any FIFO is non-empty, set cur to the first non-empty index in the order rr_ptr, rr_ptr+1, … (mod 5), then go to SEND.
  - Otherwise remain in SELECT.
- SEND:
  - M_AXIS_* is driven combinationally from the head of FIFO[cur].
  - M_AXIS_TVALID = ~empty[cur].
  - FIFO[cur] is read when M_AXIS_TVALID & M_AXIS_TREADY.
  - On an accepted beat with TLAST = 1: rr_ptr ← cur+1 mod 5, state ← SELECT.
  - An empty FIFO[cur] mid-packet stalls the output with TVALID = 0; the grant is never revoked.
- Fairness: an input that has just sent a packet has the lowest priority in the next search.
- Reset (AXI_RESETN low on any edge):
  - state ← SELECT, cur ← 0, rr_ptr ← 0.
  - All FIFOs are flushed. Any in-flight packet is dropped, and downstream may see a packet truncated without TLAST.
  - While reset is low: M_AXIS_TVALID = 0 and all Sn_AXIS_TREADY = 0.

## Timing
- Input beat written at edge t → FIFO non-empty at t+1 → SELECT grants at edge t+1 → M_AXIS_TVALID high during cycle t+1..t+2 (2-cycle minimum latency from input handshake to output valid).
- Back-to-back packets: after the TLAST handshake, exactly one SELECT bubble cycle with TVALID = 0, even when a packet is already waiting.
- Within a packet: one beat per cycle while TREADY = 1 and the FIFO is non-empty.
- M_AXIS_TDATA/TSTRB/TUSER/TLAST hold stable while TVALID = 1 and TREADY = 0.
- Outputs are X-don't-care whenever TVALID = 0.

## Configuration
- NF10_ARB_SRC_STAMP_EN defined:
  - On the first beat of each packet, M_AXIS_TUSER[SRC_PORT_POS+7:SRC_PORT_POS] is overwritten with a one-hot encoding of cur: input 0→0x01, 1→0x04, 2→0x10, 3→0x40, 4 (DMA)→0x02.
  - All other TUSER bits, and all later beats, pass through unmodified.
  - A first-beat flag register tracks the first beat: set in SELECT, cleared on the first accepted SEND beat.
- NF10_ARB_SRC_STAMP_EN undefined: TUSER passes through unmodified on every beat, and the first-beat flag register is not built.

## Test plan
- Single 3-beat packet on S2, M_AXIS_TREADY = 1 → output valid 2 cycles after the first input handshake; 3 beats in order; TLAST only on beat 3; TDATA/TSTRB/TUSER bit-exact.
- One single-beat packet queued simultaneously on each of S0–S4 → output order 0,1,2,3,4, then next grant search starts at S0; one idle cycle between packets.
- S1 sends continuously while S3 has one packet queued, rr_ptr = 2 → S3 packet emitted next, before S1's next packet.
- M_AXIS_TREADY toggled 1,0,0,1 during a 4-beat S0 packet while S4 is also pending → no beat lost or duplicated; outputs stable while stalled; S4 granted only after S0's TLAST beat.
- S0 TVALID held for 6 beats with M_AXIS_TREADY = 0 and FIFO_DEPTH_BITS = 2 → S0_AXIS_TREADY drops after 3 accepted beats; remaining beats accepted after the output drains.
- With NF10_ARB_SRC_STAMP_EN defined: packet on S4 with input TUSER[23:16] = 0x00 → first output beat TUSER[23:16] = 0x02; second beat TUSER unchanged. Then assert reset mid-packet → TVALID = 0 and TREADY = 0 during reset; next packet after reset granted from S0 search order.
